// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolver.
// Evaluates an encoded branch condition on two register operands and computes
// the next PC. The result is registered behind a valid/ready handshake. A taken
// result raises a multi-cycle flush, and saturating statistics counters track
// delivered and taken results.
module branch_resolve_unit #(
  parameter int DATA_W       = 16,
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk_pi,
  input  logic              reset_n_pi,
  input  logic              req_valid_pi,
  output logic              req_ready_po,
  input  logic [2:0]        cond_pi,
  input  logic              signed_pi,
  input  logic [DATA_W-1:0] reg1_data_pi,
  input  logic [DATA_W-1:0] reg2_data_pi,
  input  logic              alu_carry_bit_pi,
  input  logic [PC_W-1:0]   pc_pi,
  input  logic [PC_W-1:0]   offset_pi,
  output logic              res_valid_po,
  input  logic              res_ready_pi,
  output logic              is_branch_taken_po,
  output logic [PC_W-1:0]   target_pc_po,
  output logic              flush_po,
  output logic [CNT_W-1:0]  resolved_count_po,
  output logic [CNT_W-1:0]  taken_count_po
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] C_EQ    = 3'b000;
  localparam logic [2:0] C_NE    = 3'b001;
  localparam logic [2:0] C_GE    = 3'b010;
  localparam logic [2:0] C_LE    = 3'b011;
  localparam logic [2:0] C_LT    = 3'b100;
  localparam logic [2:0] C_GT    = 3'b101;
  localparam logic [2:0] C_CARRY = 3'b110;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic              res_valid_q, res_valid_d;
  logic              taken_q, taken_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  resolved_q, resolved_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic                     accept;
  logic                     deliver;
  logic                     cond_true;
  logic                     op_eq;
  logic                     op_lt;
  logic signed [DATA_W:0]   a_ext;
  logic signed [DATA_W:0]   b_ext;
  logic [PC_W-1:0]          next_pc;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ready is forced low while reset is asserted so every output reads 0.
  assign req_ready_po = reset_n_pi & (state_q == RUN) & (~res_valid_q | res_ready_pi);
  assign accept       = req_valid_pi & req_ready_po;
  assign deliver      = res_valid_q & res_ready_pi;

  // One extra bit lets a single signed comparator serve both signed and
  // unsigned compares: zero-extend for unsigned, sign-extend for signed.
  assign a_ext = {signed_pi & reg1_data_pi[DATA_W-1], reg1_data_pi};
  assign b_ext = {signed_pi & reg2_data_pi[DATA_W-1], reg2_data_pi};
  assign op_eq = (reg1_data_pi == reg2_data_pi);
  assign op_lt = (a_ext < b_ext);

  // Decode the branch condition against the current request operands.
  always_comb begin
    cond_true = 1'b1;
    case (cond_pi)
      C_EQ:    cond_true = op_eq;
      C_NE:    cond_true = ~op_eq;
      C_GE:    cond_true = ~op_lt;
      C_LE:    cond_true = op_lt | op_eq;
      C_LT:    cond_true = op_lt;
      C_GT:    cond_true = ~op_lt & ~op_eq;
      C_CARRY: cond_true = alu_carry_bit_pi;
      default: cond_true = 1'b1;
    endcase
  end

  // Next PC wraps modulo 2^PC_W by truncation.
  assign next_pc = pc_pi + (cond_true ? offset_pi : PC_W'(1));

  // Result register next-state: load on accept, otherwise drop valid on delivery.
  always_comb begin
    res_valid_d = res_valid_q;
    taken_d     = taken_q;
    target_d    = target_q;
    if (accept) begin
      res_valid_d = 1'b1;
      taken_d     = cond_true;
      target_d    = next_pc;
    end else if (deliver) begin
      res_valid_d = 1'b0;
    end
  end

  // Statistics next-state: the result leaving this cycle is counted.
  always_comb begin
    resolved_d  = resolved_q;
    taken_cnt_d = taken_cnt_q;
    if (deliver) begin
      resolved_d = sat_inc(resolved_q);
      if (taken_q) begin
        taken_cnt_d = sat_inc(taken_cnt_q);
      end
    end
  end

  // Flush FSM next-state: a taken accept starts the flush window, which
  // counts down to zero and releases on the following edge.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush_d = flush_q;
    case (state_q)
      RUN: begin
        if (accept && cond_true) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      flush_q     <= 1'b0;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      resolved_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      flush_q     <= flush_d;
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      resolved_q  <= resolved_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign res_valid_po       = res_valid_q;
  assign is_branch_taken_po = taken_q;
  assign target_pc_po       = target_q;
  assign flush_po           = flush_q;
  assign resolved_count_po  = resolved_q;
  assign taken_count_po     = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model. A second
// instance with 2-bit counters shares the same stimulus to exercise saturation.
module tb_branch_resolve_unit;

  localparam int FLUSH_CYCLES = 2;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [2:0]  cond;
  logic        sgn;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry;
  logic [15:0] pc;
  logic [15:0] off;
  logic        res_ready;

  logic        req_ready, res_valid, taken, flush;
  logic [15:0] target, res_cnt, tk_cnt;
  logic        s_req_ready, s_res_valid, s_taken, s_flush;
  logic [15:0] s_target;
  logic [1:0]  s_res_cnt, s_tk_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_valid;
  bit m_taken;
  int m_target;
  int m_flush_left;
  int m_res;
  int m_tk;

  branch_resolve_unit #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) u_dut (
    .clk_pi(clk), .reset_n_pi(reset_n), .req_valid_pi(req_valid), .req_ready_po(req_ready),
    .cond_pi(cond), .signed_pi(sgn), .reg1_data_pi(a), .reg2_data_pi(b),
    .alu_carry_bit_pi(carry), .pc_pi(pc), .offset_pi(off), .res_valid_po(res_valid),
    .res_ready_pi(res_ready), .is_branch_taken_po(taken), .target_pc_po(target),
    .flush_po(flush), .resolved_count_po(res_cnt), .taken_count_po(tk_cnt)
  );

  branch_resolve_unit #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) u_small (
    .clk_pi(clk), .reset_n_pi(reset_n), .req_valid_pi(req_valid), .req_ready_po(s_req_ready),
    .cond_pi(cond), .signed_pi(sgn), .reg1_data_pi(a), .reg2_data_pi(b),
    .alu_carry_bit_pi(carry), .pc_pi(pc), .offset_pi(off), .res_valid_po(s_res_valid),
    .res_ready_pi(res_ready), .is_branch_taken_po(s_taken), .target_pc_po(s_target),
    .flush_po(s_flush), .resolved_count_po(s_res_cnt), .taken_count_po(s_tk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Interpret the operands as integers and apply the condition directly.
  function automatic bit mdl_taken(input logic [2:0] c, input bit s,
                                   input logic [15:0] x, input logic [15:0] y, input bit cy);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    if (s) begin
      if (ix >= 32768) ix = ix - 65536;
      if (iy >= 32768) iy = iy - 65536;
    end
    case (c)
      3'd0: return ix == iy;
      3'd1: return ix != iy;
      3'd2: return ix >= iy;
      3'd3: return ix <= iy;
      3'd4: return ix < iy;
      3'd5: return ix > iy;
      3'd6: return cy;
      default: return 1'b1;
    endcase
  endfunction

  task automatic mdl_reset();
    m_valid      = 0;
    m_taken      = 0;
    m_target     = 0;
    m_flush_left = 0;
    m_res        = 0;
    m_tk         = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},  {31'd0, req_ready}, 0);
    chk({tag, "_valid"},  {31'd0, res_valid}, 0);
    chk({tag, "_taken"},  {31'd0, taken}, 0);
    chk({tag, "_target"}, {16'd0, target}, 0);
    chk({tag, "_flush"},  {31'd0, flush}, 0);
    chk({tag, "_rescnt"}, {16'd0, res_cnt}, 0);
    chk({tag, "_tkcnt"},  {16'd0, tk_cnt}, 0);
    chk({tag, "_s_ready"}, {31'd0, s_req_ready}, 0);
    chk({tag, "_s_rescnt"}, {30'd0, s_res_cnt}, 0);
  endtask

  // Asynchronous reset applied off the clock edge; outputs must clear at once.
  task automatic do_reset();
    req_valid = 0;
    reset_n   = 0;
    #1;
    check_all_zero("async_rst");
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("hold_rst");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model
  // across the rising edge using the inputs currently driven.
  task automatic cycle();
    bit exp_ready, acc, dlv, tk;
    @(negedge clk);
    exp_ready = (m_flush_left == 0) && (!m_valid || res_ready);
    chk("ready",     {31'd0, req_ready}, {31'd0, exp_ready});
    chk("valid",     {31'd0, res_valid}, {31'd0, m_valid});
    chk("taken",     {31'd0, taken}, {31'd0, m_taken});
    chk("target",    {16'd0, target}, m_target);
    chk("flush",     {31'd0, flush}, (m_flush_left > 0) ? 1 : 0);
    chk("res_cnt",   {16'd0, res_cnt}, sat(m_res, 16));
    chk("tk_cnt",    {16'd0, tk_cnt}, sat(m_tk, 16));
    chk("s_ready",   {31'd0, s_req_ready}, {31'd0, exp_ready});
    chk("s_valid",   {31'd0, s_res_valid}, {31'd0, m_valid});
    chk("s_taken",   {31'd0, s_taken}, {31'd0, m_taken});
    chk("s_target",  {16'd0, s_target}, m_target);
    chk("s_flush",   {31'd0, s_flush}, (m_flush_left > 0) ? 1 : 0);
    chk("s_res_cnt", {30'd0, s_res_cnt}, sat(m_res, 2));
    chk("s_tk_cnt",  {30'd0, s_tk_cnt}, sat(m_tk, 2));
    dlv = m_valid && res_ready;
    acc = req_valid && exp_ready;
    if (dlv) begin
      m_res++;
      if (m_taken) m_tk++;
    end
    if (m_flush_left > 0) m_flush_left--;
    if (acc) begin
      tk       = mdl_taken(cond, sgn, a, b, carry);
      m_valid  = 1;
      m_taken  = tk;
      m_target = (int'(pc) + (tk ? int'(off) : 1)) % 65536;
      if (tk) m_flush_left = FLUSH_CYCLES;
    end else if (dlv) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] c, input bit s, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] p, input logic [15:0] o);
    req_valid = 1;
    cond      = c;
    sgn       = s;
    a         = x;
    b         = y;
    carry     = 0;
    pc        = p;
    off       = o;
  endtask

  initial begin
    reset_n   = 0;
    req_valid = 0;
    cond      = 0;
    sgn       = 0;
    a         = 0;
    b         = 0;
    carry     = 0;
    pc        = 0;
    off       = 0;
    res_ready = 1;
    @(posedge clk);
    #1;

    // Reset, then reset again in the middle of a flush window.
    do_reset();
    chk("post_rst_ready", {31'd0, req_ready}, 1);
    set_req(3'd7, 0, 16'd0, 16'd0, 16'h0040, 16'h0008);
    cycle();
    req_valid = 0;
    cycle();
    chk("pre_rst_flush", {31'd0, flush}, 1);
    #2;
    do_reset();

    // Signed versus unsigned GE on 0x8000 vs 0x0001.
    res_ready = 1;
    set_req(3'd2, 0, 16'h8000, 16'h0001, 16'h0100, 16'h0020);
    cycle();
    chk("ge_uns_taken", {31'd0, taken}, 1);
    chk("ge_uns_target", {16'd0, target}, 32'h0120);
    req_valid = 0;
    repeat (FLUSH_CYCLES) cycle();
    set_req(3'd2, 1, 16'h8000, 16'h0001, 16'h0100, 16'h0020);
    cycle();
    chk("ge_sgn_taken", {31'd0, taken}, 0);
    chk("ge_sgn_target", {16'd0, target}, 32'h0101);
    req_valid = 0;
    cycle();

    // Taken EQ with negative offset, with a request waiting during the flush.
    do_reset();
    res_ready = 1;
    set_req(3'd0, 0, 16'd5, 16'd5, 16'h0010, 16'hFFFC);
    cycle();
    chk("eq_taken", {31'd0, taken}, 1);
    chk("eq_target", {16'd0, target}, 32'h000C);
    chk("eq_flush0", {31'd0, flush}, 1);
    chk("eq_ready0", {31'd0, req_ready}, 0);
    set_req(3'd1, 0, 16'd9, 16'd9, 16'h0020, 16'h0004);
    cycle();
    chk("eq_flush1", {31'd0, flush}, 1);
    chk("eq_ready1", {31'd0, req_ready}, 0);
    cycle();
    chk("eq_flush2", {31'd0, flush}, 0);
    cycle();
    req_valid = 0;
    cycle();

    // Back-to-back not-taken NE.
    do_reset();
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_req(3'd1, 0, 16'd3, 16'd3, 16'(16'h0200 + i), 16'h0040);
      cycle();
      chk("b2b_valid", {31'd0, res_valid}, 1);
    end
    req_valid = 0;
    cycle();
    chk("b2b_count", {16'd0, res_cnt}, 4);
    cycle();

    // Backpressure: result held, ready low, delivered once on release.
    do_reset();
    res_ready = 0;
    set_req(3'd1, 0, 16'd7, 16'd7, 16'h0300, 16'h0010);
    cycle();
    set_req(3'd1, 0, 16'd1, 16'd1, 16'h0400, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_target", {16'd0, target}, 32'h0301);
      chk("bp_ready", {31'd0, req_ready}, 0);
    end
    res_ready = 1;
    cycle();
    chk("bp_count", {16'd0, res_cnt}, 1);
    chk("bp_next", {16'd0, target}, 32'h0401);
    req_valid = 0;
    cycle();
    cycle();

    // PC wrap and counter saturation in the narrow-counter instance.
    do_reset();
    res_ready = 1;
    set_req(3'd7, 0, 16'd0, 16'd0, 16'hFFFF, 16'h0002);
    cycle();
    chk("wrap_target", {16'd0, target}, 32'h0001);
    req_valid = 0;
    repeat (FLUSH_CYCLES) cycle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(3'd1, 0, 16'd2, 16'd2, 16'h0500, 16'h0001);
      cycle();
    end
    req_valid = 0;
    cycle();
    chk("sat_small", {30'd0, s_res_cnt}, 3);
    chk("sat_wide", {16'd0, res_cnt}, 5);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra, rb;
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 9) < 7);
      cond      = 3'($urandom_range(0, 7));
      sgn       = 1'($urandom_range(0, 1));
      carry     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
      a   = ra;
      b   = rb;
      pc  = 16'($urandom);
      off = 16'($urandom);
      cycle();
    end
    req_valid = 0;
    res_ready = 1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
